// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one operand bit per cycle, on operand magnitudes.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes; only signed ops (MDOp[0]=1) take the absolute value.
    always_comb begin
        mag_a = (MDOp[0] && A[WIDTH-1]) ? WIDTH'(-A) : A;
        mag_b = (MDOp[0] && B[WIDTH-1]) ? WIDTH'(-B) : B;
    end

    // One iteration: acc holds {partial_high, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!is_div) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up applied in FIN; remainder follows the dividend's sign.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (2*WIDTH)'(-acc) : acc;
        quo_fix  = (sign_a ^ sign_b) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = sign_a ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start && !MDOp[2]) begin
                        state    <= S_RUN;
                        Busy     <= 1'b1;
                        cnt      <= CW'(WIDTH);
                        is_div   <= MDOp[1];
                        sign_a   <= MDOp[0] & A[WIDTH-1];
                        sign_b   <= MDOp[0] & B[WIDTH-1];
                        div_zero <= (B == '0);
                        a_raw    <= A;
                        opnd     <= MDOp[1] ? mag_b : mag_a;
                        acc      <= {WIDTH'(0), (MDOp[1] ? mag_a : mag_b)};
                    end else if (Start && !MDOp[1]) begin
                        if (MDOp[0]) Lo <= A;
                        else         Hi <= A;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_FIN;
                end
                S_FIN: begin
                    if (!is_div) begin
                        Hi <= prod_fix[2*WIDTH-1:WIDTH];
                        Lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        Hi <= a_raw;
                        Lo <= '1;
                    end else begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
